// File: rtl/four_bit_subtractor_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : four_bit_subtractor_serial                                   |
// | Description : Bit-serial 4-bit unsigned subtractor, LSB first, one bit per |
// |               clock. Diff = {Bout, (A - B - Bin) mod 16}.                  |
// |               Optional macro SUB_OVF_EN adds a signed-overflow output Ovf. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module four_bit_subtractor_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Bin,
  output logic [4:0] Diff,
  output logic       Busy,
  output logic       Done
`ifdef SUB_OVF_EN
  ,
  output logic       Ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] c_CNT_LAST = 2'd3;

  state_t     r_state;
  logic [3:0] r_a;        // operands latched at the Start edge
  logic [3:0] r_b;
  logic       r_br;       // running borrow
  logic [1:0] r_cnt;      // index of the bit being processed
  logic [2:0] r_acc;      // lower difference bits, shifted in LSB first

  logic w_a;
  logic w_b;
  logic w_d;
  logic w_br_nxt;

  // One full-subtractor slice on the current bit position
  assign w_a      = r_a[r_cnt];
  assign w_b      = r_b[r_cnt];
  assign w_d      = w_a ^ w_b ^ r_br;
  assign w_br_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);

  // Control FSM, serial datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_br    <= 1'b0;
      r_cnt   <= 2'd0;
      r_acc   <= 3'd0;
      Diff    <= 5'd0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
`ifdef SUB_OVF_EN
      Ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bin;
            r_cnt   <= 2'd0;
            Busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + 2'd1;
          r_acc <= {w_d, r_acc[2:1]};
          if (r_cnt == c_CNT_LAST) begin
            // Last bit: publish the whole result at once so Diff never shows partials
            Diff    <= {w_br_nxt, w_d, r_acc};
`ifdef SUB_OVF_EN
            Ovf     <= (r_a[3] ^ r_b[3]) & (w_d ^ r_a[3]);
`endif
            Busy    <= 1'b0;
            Done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Start is deliberately ignored here; always go back through IDLE
          Done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_four_bit_subtractor_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_four_bit_subtractor_serial                                |
// | Description : Scoreboard bench for four_bit_subtractor_serial with         |
// |               directed, hand-computed vectors.                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_four_bit_subtractor_serial;

  logic       clk;
  logic       rst_n;
  logic       Start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic [4:0] Diff;
  logic       Busy;
  logic       Done;
`ifdef SUB_OVF_EN
  logic       Ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int n_issued = 0;
  int n_done   = 0;

  // {ovf, diff[4:0]} expected per accepted operation
  logic [5:0] exp_q[$];

  four_bit_subtractor_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Diff  (Diff),
    .Busy  (Busy),
    .Done  (Done)
`ifdef SUB_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse pops one expected result and compares
  always @(negedge clk) begin
    if (rst_n === 1'b1 && Done === 1'b1) begin
      n_done++;
      chk("busy_with_done", {31'd0, Busy}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("diff", {27'd0, Diff}, {27'd0, e[4:0]});
`ifdef SUB_OVF_EN
        chk("ovf", {31'd0, Ovf}, {31'd0, e[5]});
`endif
      end
    end
  end

  // One operation with Start pulsed for a single edge, operands scrambled afterwards
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic [4:0] exp_diff, input logic exp_ovf);
    @(negedge clk);
    A = a; B = b; Bin = bin; Start = 1'b1;
    exp_q.push_back({exp_ovf, exp_diff});
    n_issued++;
    @(posedge clk);
    #1;
    Start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_phase", {30'd0, Busy, Done}, 32'd2);
    end
    @(negedge clk);
    chk("done_phase", {30'd0, Busy, Done}, 32'd1);
    @(negedge clk);
    chk("idle_phase", {30'd0, Busy, Done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; Start = 1'b0; A = 4'd0; B = 4'd0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_diff", {27'd0, Diff}, 32'd0);
    chk("rst_busy_done", {30'd0, Busy, Done}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors: a, b, bin, {Bout,D}, signed overflow
    run_op(4'd9,  4'd3,  1'b0, 5'b00110, 1'b1);
    run_op(4'd3,  4'd9,  1'b0, 5'b11010, 1'b1);
    run_op(4'd0,  4'd0,  1'b1, 5'b11111, 1'b0);
    run_op(4'd0,  4'd15, 1'b1, 5'b10000, 1'b0);
    run_op(4'd5,  4'd5,  1'b0, 5'b00000, 1'b0);
    run_op(4'd8,  4'd1,  1'b0, 5'b00111, 1'b1);
    run_op(4'd7,  4'd1,  1'b0, 5'b00110, 1'b0);
    run_op(4'd12, 4'd4,  1'b1, 5'b00111, 1'b1);

    // Start held high through SHIFT with operands changing: only one result
    @(negedge clk);
    A = 4'd9; B = 4'd3; Bin = 1'b0; Start = 1'b1;
    exp_q.push_back({1'b1, 5'b00110});
    n_issued++;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
      chk("held_busy", {30'd0, Busy, Done}, 32'd2);
    end
    @(negedge clk);
    Start = 1'b0;
    chk("held_done", {30'd0, Busy, Done}, 32'd1);
    @(negedge clk);
    chk("held_idle", {30'd0, Busy, Done}, 32'd0);

    // Back-to-back operation right after the previous one
    run_op(4'd15, 4'd0, 1'b1, 5'b01110, 1'b0);

    // Reset asserted between edges k+1 and k+2 aborts the operation
    @(negedge clk);
    A = 4'd6; B = 4'd2; Bin = 1'b0; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy_done", {30'd0, Busy, Done}, 32'd0);
    chk("abort_diff", {27'd0, Diff}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    run_op(4'd6, 4'd2, 1'b0, 5'b00100, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("done_count", n_done, n_issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
